// File: rtl/ps_pwm_modulator.sv
// Phase-shifted-carrier PWM modulator for the cascaded H-bridge active filter.
// N_CELLS triangular carriers, unipolar two-leg switching, per-leg dead time, enable and latched fault.
module ps_pwm_modulator #(
   parameter int N_CELLS       = 3,
   parameter int CW            = 16,
   parameter int PERIOD        = 1000,
   parameter int DT            = 8,
   parameter bit DOUBLE_UPDATE = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic signed [CW-1:0]   mod,
   input  logic                   en,
   input  logic                   fault,
   input  logic                   fault_clr,
   output logic [4*N_CELLS-1:0]   gate,
   output logic                   sync,
   output logic                   fault_latched
);

   // Legs are numbered 2k (leg A) and 2k+1 (leg B) for cell k.
   localparam int NL = 2 * N_CELLS;
   localparam logic [CW-1:0]        PEAK = CW'(PERIOD);
   localparam logic signed [CW-1:0] HALF = CW'(PERIOD / 2);
   localparam logic [7:0]           DT_L = 8'(DT);

   function automatic logic [CW-1:0] reset_cnt(input int k);
      int p;
      p = (k * 2 * PERIOD) / N_CELLS;
      if (p <= PERIOD) begin
         return CW'(p);
      end else begin
         return CW'(2 * PERIOD - p);
      end
   endfunction

   function automatic logic reset_up(input int k);
      int p;
      p = (k * 2 * PERIOD) / N_CELLS;
      return (p <= PERIOD);
   endfunction

   logic [CW-1:0]        cnt_q [N_CELLS];
   logic [CW-1:0]        cnt_d [N_CELLS];
   logic [N_CELLS-1:0]   up_q, up_d;
   logic signed [CW-1:0] carrier_s [N_CELLS];
   logic signed [CW-1:0] mod_s_q, mod_s_d, mod_sat_s, neg_mod_s;
   logic                 sample_s, blank_s;
   logic [NL-1:0]        cmd_q, cmd_d;
   logic [NL-1:0]        tgt_q, tgt_d;
   logic [7:0]           dt_q [NL];
   logic [7:0]           dt_d [NL];
   logic [NL-1:0]        hi_q, hi_d, lo_q, lo_d;
   logic                 sync_q, sync_d;
   logic                 flt_q, flt_d;

   // Next-state logic for carriers, reference sampling, leg commands and dead time.
   always_comb begin
      for (int k = 0; k < N_CELLS; k++) begin
         if (up_q[k]) begin
            if (cnt_q[k] == PEAK) begin
               cnt_d[k] = PEAK - CW'(1);
               up_d[k]  = 1'b0;
            end else begin
               cnt_d[k] = cnt_q[k] + CW'(1);
               up_d[k]  = 1'b1;
            end
         end else begin
            if (cnt_q[k] == CW'(0)) begin
               cnt_d[k] = CW'(1);
               up_d[k]  = 1'b1;
            end else begin
               cnt_d[k] = cnt_q[k] - CW'(1);
               up_d[k]  = 1'b0;
            end
         end
      end

      if (mod > HALF) begin
         mod_sat_s = HALF;
      end else if (mod < -HALF) begin
         mod_sat_s = -HALF;
      end else begin
         mod_sat_s = mod;
      end

      sample_s = (cnt_q[0] == CW'(0)) || ((DOUBLE_UPDATE != 1'b0) && (cnt_q[0] == PEAK));
      if (sample_s) begin
         mod_s_d = mod_sat_s;
      end else begin
         mod_s_d = mod_s_q;
      end

      // Saturation keeps -mod_s inside the signed range, so negation cannot wrap.
      neg_mod_s = -mod_s_q;
      for (int k = 0; k < N_CELLS; k++) begin
         carrier_s[k]    = $signed(cnt_q[k]) - HALF;
         cmd_d[2*k]      = (mod_s_q > carrier_s[k]);
         cmd_d[2*k + 1]  = (neg_mod_s > carrier_s[k]);
      end

      sync_d = (cnt_q[0] == CW'(0));

      if (fault) begin
         flt_d = 1'b1;
      end else if (fault_clr) begin
         flt_d = 1'b0;
      end else begin
         flt_d = flt_q;
      end

      // A clear request counts as the re-arm cycle, exactly like the first cycle of en high.
      blank_s = !en || fault || (flt_q && !fault_clr);

      for (int l = 0; l < NL; l++) begin
         tgt_d[l] = cmd_q[l];
         if (blank_s) begin
            dt_d[l] = DT_L;
            hi_d[l] = 1'b0;
            lo_d[l] = 1'b0;
         end else if (cmd_q[l] != tgt_q[l]) begin
            dt_d[l] = DT_L;
            if (DT == 0) begin
               hi_d[l] = cmd_q[l];
               lo_d[l] = ~cmd_q[l];
            end else begin
               hi_d[l] = 1'b0;
               lo_d[l] = 1'b0;
            end
         end else if (dt_q[l] > 8'd1) begin
            dt_d[l] = dt_q[l] - 8'd1;
            hi_d[l] = 1'b0;
            lo_d[l] = 1'b0;
         end else begin
            dt_d[l] = 8'd0;
            hi_d[l] = tgt_q[l];
            lo_d[l] = ~tgt_q[l];
         end
      end
   end

   // State registers; counters start at their phase offsets so all cells are shifted from reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_CELLS; k++) begin
            cnt_q[k] <= reset_cnt(k);
            up_q[k]  <= reset_up(k);
         end
         for (int l = 0; l < NL; l++) begin
            dt_q[l] <= DT_L;
         end
         mod_s_q <= '0;
         cmd_q   <= '0;
         tgt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         sync_q  <= 1'b0;
         flt_q   <= 1'b0;
      end else begin
         for (int k = 0; k < N_CELLS; k++) begin
            cnt_q[k] <= cnt_d[k];
            up_q[k]  <= up_d[k];
         end
         for (int l = 0; l < NL; l++) begin
            dt_q[l] <= dt_d[l];
         end
         mod_s_q <= mod_s_d;
         cmd_q   <= cmd_d;
         tgt_q   <= tgt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         sync_q  <= sync_d;
         flt_q   <= flt_d;
      end
   end

   // Gate bus wiring: leg l drives bits 2l (high side) and 2l+1 (low side).
   always_comb begin
      gate = '0;
      for (int l = 0; l < NL; l++) begin
         gate[2*l]     = hi_q[l];
         gate[2*l + 1] = lo_q[l];
      end
   end

   assign sync          = sync_q;
   assign fault_latched = flt_q;

endmodule

// File: tb/tb_ps_pwm_modulator.sv
// Directed bench for ps_pwm_modulator (N_CELLS=3, PERIOD=1000, DT=8) with hand-computed expectations.
module tb_ps_pwm_modulator;

   localparam int N  = 3;
   localparam int CW = 16;
   localparam int P  = 1000;
   localparam int DT = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic signed [CW-1:0] mod;
   logic                 en, fault, fault_clr;
   logic [4*N-1:0]       gate;
   logic                 sync, fault_latched;

   int checks = 0;
   int failures = 0;
   int overlap_cnt = 0;
   int hi_cnt [4*N];
   int first_rise [N];
   int gap_runs, gap_bad, short_pulses;
   logic [2*N-1:0] hi_v, lo_v;

   ps_pwm_modulator #(.N_CELLS(N), .CW(CW), .PERIOD(P), .DT(DT), .DOUBLE_UPDATE(1'b1)) dut (
      .clk(clk), .rst(rst), .mod(mod), .en(en), .fault(fault), .fault_clr(fault_clr),
      .gate(gate), .sync(sync), .fault_latched(fault_latched)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int l = 0; l < 2*N; l++) begin
         hi_v[l] = gate[2*l];
         lo_v[l] = gate[2*l + 1];
      end
   end

   // Shoot-through watch across the whole run.
   always @(negedge clk) begin
      if (!rst && (|(hi_v & lo_v))) overlap_cnt <= overlap_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic window(input int n);
      logic [4*N-1:0] prev;
      int gap;
      int run [2*N];
      prev = gate;
      gap = -1;
      gap_runs = 0; gap_bad = 0; short_pulses = 0;
      for (int b = 0; b < 4*N; b++) hi_cnt[b] = 0;
      for (int k = 0; k < N; k++) first_rise[k] = -1;
      for (int l = 0; l < 2*N; l++) run[l] = prev[2*l] ? -1 : 0;
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < 4*N; b++) if (gate[b]) hi_cnt[b]++;
         for (int k = 0; k < N; k++)
            if (gate[4*k] && !prev[4*k] && first_rise[k] < 0) first_rise[k] = i;
         if (!gate[0] && !gate[1]) begin
            if (gap >= 0) gap++;
         end else begin
            if (gap > 0) begin
               gap_runs++;
               if (gap != DT) gap_bad++;
            end
            gap = 0;
         end
         for (int l = 0; l < 2*N; l++) begin
            if (gate[2*l]) begin
               if (run[l] >= 0) run[l]++;
            end else begin
               if (run[l] > 0 && run[l] < DT) short_pulses++;
               run[l] = 0;
            end
         end
         prev = gate;
         step();
      end
   endtask

   initial begin
      int n;
      int d1, d2;
      rst = 1'b1; mod = 16'sd250; en = 1'b1; fault = 1'b0; fault_clr = 1'b0;
      repeat (3) step();
      chk("reset_gate", gate, 12'h000);
      chk("reset_sync", sync, 1'b0);
      chk("reset_fault_latched", fault_latched, 1'b0);

      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("startup_blank", gate, 12'h000);
         if (i == 1) chk("sync_first", sync, 1'b1);
         if (i == 2) chk("sync_low", sync, 1'b0);
         step();
      end
      // Only legs whose command never moved since reset (cell1/cell2 leg B, low side) come on at cycle 8.
      chk("first_turn_on", gate, 12'h880);

      n = 8;
      while (!sync && n < 2100) begin step(); n++; end
      chk("sync_period", n, 2001);

      // Duty at mod=+250: cmdA high 1499 cycles/period, cmdB 499, each minus DT.
      window(2000);
      chk("duty_c0_tr0", hi_cnt[0], 1491);
      chk("duty_c0_tr1", hi_cnt[1], 493);
      chk("duty_c0_tr2", hi_cnt[2], 491);
      chk("duty_c0_tr3", hi_cnt[3], 1493);
      chk("duty_c1_tr0", hi_cnt[4], 1491);
      chk("duty_c2_tr0", hi_cnt[8], 1491);
      chk("deadtime_gap_count", gap_runs, 2);
      chk("deadtime_gap_len", gap_bad, 0);
      chk("sync_steady", sync, 1'b1);

      // Saturated step applied mid-period (window start s has cnt0=1).
      repeat (100) step();
      mod = 16'sd2000;
      repeat (800) step();
      chk("hold_until_sample", gate[3:0], 4'hA);
      repeat (101) step();
      chk("update_cmd_cycle", gate[3:0], 4'hA);
      step();
      chk("update_off", gate[3:0], 4'h8);
      repeat (7) step();
      chk("update_deadtime", gate[3:0], 4'h8);
      step();
      chk("update_on", gate[3:0], 4'h9);
      repeat (990) step();
      window(2000);
      for (int k = 0; k < N; k++) begin
         chk("sat_tr0", hi_cnt[4*k], 1991);
         chk("sat_tr1", hi_cnt[4*k + 1], 0);
         chk("sat_tr2", hi_cnt[4*k + 2], 0);
         chk("sat_tr3", hi_cnt[4*k + 3], 2000);
      end
      chk("sat_short_pulses", short_pulses, 0);

      // Phase shift at mod=0.
      mod = 16'sd0;
      repeat (1500) step();
      window(2100);
      d1 = ((first_rise[0] - first_rise[1]) % 2000 + 2000) % 2000;
      d2 = ((first_rise[0] - first_rise[2]) % 2000 + 2000) % 2000;
      chk("phase_cell1", d1, 666);
      chk("phase_cell2", d2, 1333);

      // Fault shutdown, ignored clear, re-arm.
      n = 0;
      while (!gate[0] && n < 2100) begin step(); n++; end
      chk("pulse_found", gate[0], 1'b1);
      repeat (5) step();
      fault = 1'b1;
      step();
      chk("fault_blank", gate, 12'h000);
      chk("fault_latch_set", fault_latched, 1'b1);
      fault_clr = 1'b1;
      step();
      fault_clr = 1'b0;
      chk("clr_ignored", fault_latched, 1'b1);
      repeat (3) step();
      fault = 1'b0;
      repeat (3) step();
      chk("latch_holds", fault_latched, 1'b1);
      chk("latch_blank", gate, 12'h000);
      fault_clr = 1'b1;
      step();
      fault_clr = 1'b0;
      chk("latch_cleared", fault_latched, 1'b0);
      chk("rearm_blank", gate, 12'h000);
      for (int i = 2; i < 8; i++) begin
         step();
         chk("rearm_blank", gate, 12'h000);
      end
      step();
      chk("rearm_on", gate, 12'hA55);

      // Enable blanking without latch.
      repeat (5) step();
      en = 1'b0;
      step();
      chk("en_blank", gate, 12'h000);
      chk("en_no_latch", fault_latched, 1'b0);
      repeat (3) step();
      chk("en_blank_hold", gate, 12'h000);
      en = 1'b1;
      for (int i = 1; i < 8; i++) begin
         step();
         chk("en_rearm_blank", gate, 12'h000);
      end
      step();
      chk("en_rearm_on", gate, 12'hA55);

      chk("no_shoot_through", overlap_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
